// File: rtl/imem_ctrl.sv
// imem_ctrl: shared-port instruction memory controller (loader/fetch).
// Define IMEM_CLEAR_EN to zero the whole memory on entering LOAD.
module imem_ctrl #(
  parameter int          RAM_WIDTH     = 32,
  parameter int          RAM_ADDR_BITS = 10,
  parameter logic [31:0] HALT_WORD     = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_load,
  input  logic                     cmd_run,
  input  logic                     cmd_step,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_byte,
  output logic                     ld_ready,
  input  logic                     fetch_req,
  input  logic [RAM_ADDR_BITS-1:0] fetch_addr,
  output logic [RAM_WIDTH-1:0]     fetch_data,
  output logic                     fetch_valid,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata,
  output logic                     pipe_en,
  output logic [RAM_ADDR_BITS:0]   prog_len,
  output logic [2:0]               state_o
);

  localparam int AW = RAM_ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [RAM_WIDTH-1:0] word;
  logic [1:0]           byte_cnt;
  logic                 wr_pend;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          len_q;
  logic                 fv_q;
  logic [RAM_WIDTH-1:0] fd_q;
  logic                 clr_q;
  logic                 fetch_st;
  logic                 halt_seen;
  logic                 wr_last;
  logic                 start_load;
  logic                 load_open;

  assign fetch_st   = (state == RUN) || (state == STEP);
  assign halt_seen  = fv_q && (mem_rdata == HALT_WORD);
  assign start_load = cmd_load && ((state == IDLE) || (state == HALT));
  assign load_open  = (state == LOAD) && !wr_pend && !clr_q;
  assign wr_last    = wr_pend &&
                      ((word == HALT_WORD) || (wr_ptr == {AW{1'b1}}));

  assign ld_ready    = load_open;
  assign fetch_valid = fv_q;
  assign fetch_data  = fv_q ? mem_rdata : fd_q;
  assign prog_len    = len_q;
  assign state_o     = state;
  assign mem_we      = wr_pend || clr_q;
  assign mem_wdata   = wr_pend ? word : '0;

  // Port address: loader pointer while loading, PC while executing
  always_comb begin
    mem_addr = '0;
    if (state == LOAD)
      mem_addr = wr_ptr;
    else if (fetch_st)
      mem_addr = fetch_addr;
  end

  // Mode sequencing and pipeline enable
  always_comb begin
    state_nx = state;
    pipe_en  = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (cmd_load)
          state_nx = LOAD;
        else if (cmd_run)
          state_nx = RUN;
        else if (cmd_step)
          state_nx = STEP;
      end
      LOAD: begin
        if (wr_last)
          state_nx = IDLE;
      end
      RUN: begin
        pipe_en = !halt_seen;
        if (halt_seen)
          state_nx = HALT;
      end
      STEP: begin
        pipe_en  = 1'b1;
        state_nx = halt_seen ? HALT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

`ifndef IMEM_CLEAR_EN
  assign clr_q = 1'b0;
`endif

  // Byte assembly, word write and program length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
      wr_pend  <= 1'b0;
      wr_ptr   <= '0;
      len_q    <= '0;
`ifdef IMEM_CLEAR_EN
      clr_q    <= 1'b0;
`endif
    end else if (start_load) begin
      word     <= '0;
      byte_cnt <= '0;
      wr_pend  <= 1'b0;
      wr_ptr   <= '0;
      len_q    <= '0;
`ifdef IMEM_CLEAR_EN
      clr_q    <= 1'b1;
`endif
    end else if (state == LOAD) begin
`ifdef IMEM_CLEAR_EN
      if (clr_q) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == {AW{1'b1}})
          clr_q <= 1'b0;
      end else
`endif
      if (wr_pend) begin
        wr_pend <= 1'b0;
        wr_ptr  <= wr_ptr + 1'b1;
        len_q   <= len_q + 1'b1;
      end else if (ld_valid) begin
        word     <= {word[RAM_WIDTH-9:0], ld_byte};
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == 2'd3)
          wr_pend <= 1'b1;
      end
    end
  end

  // Fetch valid follows the request by one cycle; data held when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q <= 1'b0;
      fd_q <= '0;
    end else begin
      fv_q <= fetch_st && fetch_req;
      if (fv_q)
        fd_q <= mem_rdata;
    end
  end

endmodule
